// File: rtl/sysid_boot_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sysid_pkg
// Description : Shared types and constants for the system-ID slave and its
//               boot-time checker.
// Revision    : 1.0
// ============================================================================
package sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_RD_TS = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } sysid_state_t;

    localparam logic        SYSID_ADDR_ID    = 1'b0;
    localparam logic        SYSID_ADDR_TS    = 1'b1;

    localparam logic [31:0] SYSID_DEF_EXP_ID = 32'd0;
    localparam logic [31:0] SYSID_DEF_EXP_TS = 32'd1408928828;

endpackage
`default_nettype wire

// File: rtl/sysid_boot_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : sysid_boot_checker_if
// Description : Avalon-MM read-only link between the checker and the
//               system-ID slave.
// Revision    : 1.0
// ============================================================================
interface sysid_boot_checker_if;

    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface
`default_nettype wire

// File: rtl/sysid_boot_checker_tmo_counter.sv
`default_nettype none
// ============================================================================
// Module      : sysid_tmo_counter
// Description : Waitrequest stall counter, cleared at the start of each read.
// Revision    : 1.0
// ============================================================================
module sysid_tmo_counter #(
    parameter int TMO_CYCLES = 256
) (
    input  wire logic clock,
    input  wire logic reset_n,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_expired
);

    localparam int            CW     = $clog2(TMO_CYCLES) + 1;
    localparam logic [CW-1:0] C_LAST = CW'(TMO_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Saturates at the last value so an unserviced expiry cannot wrap around.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != C_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/sysid_boot_checker.sv
`default_nettype none
// ============================================================================
// Module      : sysid_boot_checker
// Description : Reads system ID and build timestamp after reset or on start,
//               compares them to expected values, reports sticky status.
// Revision    : 1.0
// ============================================================================
module sysid_boot_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXP_ID     = SYSID_DEF_EXP_ID,
    parameter logic [31:0] EXP_TS     = SYSID_DEF_EXP_TS,
    parameter int          TMO_CYCLES = 256,
    parameter bit          AUTO_START = 1'b1
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    input  wire logic             start,
    sysid_boot_checker_if.master  avm,
    output logic                  busy,
    output logic                  done,
    output logic                  id_match,
    output logic                  ts_match,
    output logic                  timeout,
    output logic [31:0]           id_value,
    output logic [31:0]           ts_value
);

    sysid_state_t r_state, w_state_nxt;
    logic         r_pending, w_pending_nxt;
    logic         r_read, w_read_nxt;
    logic         r_addr, w_addr_nxt;
    logic         r_busy, w_busy_nxt;
    logic         r_done, w_done_nxt;
    logic         r_id_match, w_id_match_nxt;
    logic         r_ts_match, w_ts_match_nxt;
    logic         r_timeout, w_timeout_nxt;
    logic [31:0]  r_id_value, w_id_value_nxt;
    logic [31:0]  r_ts_value, w_ts_value_nxt;
    logic         w_cnt_clr, w_cnt_en, w_expired;

    sysid_tmo_counter #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_tmo (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_clr     (w_cnt_clr),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_pending  <= AUTO_START;
            r_read     <= 1'b0;
            r_addr     <= SYSID_ADDR_ID;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_id_match <= 1'b0;
            r_ts_match <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_read     <= w_read_nxt;
            r_addr     <= w_addr_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_id_match <= w_id_match_nxt;
            r_ts_match <= w_ts_match_nxt;
            r_timeout  <= w_timeout_nxt;
            r_id_value <= w_id_value_nxt;
            r_ts_value <= w_ts_value_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pending_nxt  = r_pending;
        w_read_nxt     = r_read;
        w_addr_nxt     = r_addr;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_id_match_nxt = r_id_match;
        w_ts_match_nxt = r_ts_match;
        w_timeout_nxt  = r_timeout;
        w_id_value_nxt = r_id_value;
        w_ts_value_nxt = r_ts_value;
        w_cnt_clr      = 1'b0;
        w_cnt_en       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start || r_pending) begin
                    w_state_nxt    = ST_RD_ID;
                    w_pending_nxt  = 1'b0;
                    w_done_nxt     = 1'b0;
                    w_id_match_nxt = 1'b0;
                    w_ts_match_nxt = 1'b0;
                    w_timeout_nxt  = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_read_nxt     = 1'b1;
                    w_addr_nxt     = SYSID_ADDR_ID;
                    w_cnt_clr      = 1'b1;
                end
            end
            ST_RD_ID: begin
                if (!avm.avm_waitrequest) begin
                    w_id_value_nxt = avm.avm_readdata;
                    w_id_match_nxt = (avm.avm_readdata == EXP_ID);
                    w_addr_nxt     = SYSID_ADDR_TS;
                    w_cnt_clr      = 1'b1;
                    w_state_nxt    = ST_RD_TS;
                end else if (w_expired) begin
                    w_state_nxt    = ST_ERR;
                end else begin
                    w_cnt_en       = 1'b1;
                end
            end
            ST_RD_TS: begin
                if (!avm.avm_waitrequest) begin
                    w_ts_value_nxt = avm.avm_readdata;
                    w_ts_match_nxt = (avm.avm_readdata == EXP_TS);
                    w_read_nxt     = 1'b0;
                    w_state_nxt    = ST_DONE;
                end else if (w_expired) begin
                    w_state_nxt    = ST_ERR;
                end else begin
                    w_cnt_en       = 1'b1;
                end
            end
            ST_DONE: begin
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                // Match flag of the word that never arrived was cleared at start.
                w_read_nxt    = 1'b0;
                w_timeout_nxt = 1'b1;
                w_done_nxt    = 1'b1;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign avm.avm_read    = r_read;
    assign avm.avm_address = r_addr;
    assign busy            = r_busy;
    assign done            = r_done;
    assign id_match        = r_id_match;
    assign ts_match        = r_ts_match;
    assign timeout         = r_timeout;
    assign id_value        = r_id_value;
    assign ts_value        = r_ts_value;

endmodule
`default_nettype wire

// File: tb/tb_sysid_boot_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysid_boot_checker
// Description : Randomized scoreboard bench for sysid_boot_checker.
// Revision    : 1.0
// ============================================================================
module tb_sysid_boot_checker;
    import sysid_pkg::*;

    localparam int          T   = 8;
    localparam logic [31:0] EID = SYSID_DEF_EXP_ID;
    localparam logic [31:0] ETS = SYSID_DEF_EXP_TS;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        busy, done, id_match, ts_match, timeout;
    logic [31:0] id_value, ts_value;

    sysid_boot_checker_if avm_if ();

    sysid_boot_checker #(
        .EXP_ID     (EID),
        .EXP_TS     (ETS),
        .TMO_CYCLES (T),
        .AUTO_START (1'b1)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .avm      (avm_if),
        .busy     (busy),
        .done     (done),
        .id_match (id_match),
        .ts_match (ts_match),
        .timeout  (timeout),
        .id_value (id_value),
        .ts_value (ts_value)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        idm, tsm, tmo;
        logic [31:0] idv, tsv;
        int          lat;
        int          reads;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_idv = '0, m_tsv = '0;
    int          n_checks = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    endtask

    // Behavioural slave: stalls a configurable number of cycles per word.
    int          sl_stall[2];
    logic [31:0] sl_word[2];
    int          sl_cnt = 0;

    initial begin
        avm_if.avm_waitrequest = 1'b0;
        avm_if.avm_readdata    = '0;
    end

    always @(posedge clock) begin
        #2;
        if (!avm_if.avm_read) begin
            sl_cnt = 0;
            avm_if.avm_waitrequest = 1'b0;
            avm_if.avm_readdata    = $urandom;
        end else if (sl_cnt < sl_stall[avm_if.avm_address]) begin
            sl_cnt++;
            avm_if.avm_waitrequest = 1'b1;
            avm_if.avm_readdata    = $urandom;
        end else begin
            sl_cnt = 0;
            avm_if.avm_waitrequest = 1'b0;
            avm_if.avm_readdata    = sl_word[avm_if.avm_address];
        end
    end

    // Reference model: outcome of one check from stall lengths and words.
    task automatic push_exp(input int s0, input int s1, input logic [31:0] w0, input logic [31:0] w1);
        exp_t e;
        e.tmo = 1'b0; e.idm = 1'b0; e.tsm = 1'b0;
        if (s0 >= T) begin
            e.tmo = 1'b1; e.lat = T + 1; e.reads = 0;
        end else begin
            m_idv = w0;
            e.idm = (w0 == EID);
            if (s1 >= T) begin
                e.tmo = 1'b1; e.lat = s0 + T + 2; e.reads = 1;
            end else begin
                m_tsv = w1;
                e.tsm = (w1 == ETS);
                e.lat = s0 + s1 + 3; e.reads = 2;
            end
        end
        e.idv = m_idv;
        e.tsv = m_tsv;
        sb_q.push_back(e);
    endtask

    // Monitor: scores each completed check and bus stability during stalls.
    int   cyc = 0, busy_cyc = 0, acc = 0;
    logic prev_busy = 1'b0, prev_done = 1'b0, stab = 1'b0, prev_read = 1'b0, prev_addr = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (!reset_n) begin
            acc = 0; prev_busy = 1'b0; prev_done = 1'b0; stab = 1'b0;
        end else begin
            if (busy && !prev_busy) busy_cyc = cyc;
            if (stab && !timeout)
                chk("stall_hold", 32'({avm_if.avm_read, avm_if.avm_address}), 32'({prev_read, prev_addr}));
            stab      = avm_if.avm_read && avm_if.avm_waitrequest;
            prev_read = avm_if.avm_read;
            prev_addr = avm_if.avm_address;
            if (avm_if.avm_read && !avm_if.avm_waitrequest) acc++;
            if (done && !prev_done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("id_match", 32'(id_match), 32'(e.idm));
                    chk("ts_match", 32'(ts_match), 32'(e.tsm));
                    chk("timeout",  32'(timeout),  32'(e.tmo));
                    chk("id_value", id_value, e.idv);
                    chk("ts_value", ts_value, e.tsv);
                    chk("busy_at_done", 32'(busy), 32'd0);
                    chk("latency", 32'(cyc - busy_cyc), 32'(e.lat));
                    chk("reads", 32'(acc), 32'(e.reads));
                end
                acc = 0;
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    task automatic cfg(input int s0, input int s1, input logic [31:0] w0, input logic [31:0] w1);
        sl_stall[0] = s0; sl_stall[1] = s1;
        sl_word[0]  = w0; sl_word[1]  = w1;
    endtask

    // mode 1: stray start in 2nd busy cycle; mode 2: stray start in DONE cycle.
    task automatic wait_done(input int mode, output int n);
        bit ok = 1'b0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            start = 1'b0;
            n++;
            if (done && !busy) begin ok = 1'b1; break; end
            if (mode == 1 && i == 1) start = 1'b1;
            if (mode == 2 && busy && !avm_if.avm_read) start = 1'b1;
        end
        start = 1'b0;
        if (!ok) chk("wait_done_bound", 32'(done), 32'd1);
    endtask

    task automatic run_check(input int s0, input int s1, input logic [31:0] w0,
                             input logic [31:0] w1, input int mode);
        int n;
        cfg(s0, s1, w0, w1);
        push_exp(s0, s1, w0, w1);
        @(negedge clock);
        start = 1'b1;
        wait_done(mode, n);
        if (mode != 0) begin
            repeat (3) @(negedge clock);
            chk("stray_start_ignored", 32'({busy, done}), 32'b01);
        end
    endtask

    function automatic int rand_stall();
        int r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 3);
        if (r < 8) return T - 1;
        return T + 3 + $urandom_range(0, 5);
    endfunction

    initial begin
        int n;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] w0, w1;
        cfg(0, 0, EID, ETS);
        repeat (2) @(negedge clock);
        #1;
        chk("reset_flags", 32'({busy, done, id_match, ts_match, timeout, avm_if.avm_read, avm_if.avm_address}), 32'd0);
        chk("reset_id_value", id_value, 32'd0);
        chk("reset_ts_value", ts_value, 32'd0);

        // Auto-start after reset release with a zero-wait, matching slave.
        push_exp(0, 0, EID, ETS);
        @(negedge clock);
        reset_n = 1'b1;
        wait_done(0, n);
        chk("autostart_edges", 32'(n), 32'd4);

        run_check(0, 0, EID, ETS + 32'd1, 0);
        run_check(3, 3, EID, ETS, 0);
        run_check(0, 100, EID, ETS, 0);
        run_check(100, 0, EID, ETS, 0);
        run_check(T - 1, T - 1, EID, ETS, 0);
        run_check(0, 0, EID, ETS, 1);
        run_check(1, 2, 32'hDEAD_BEEF, ETS, 2);

        for (int k = 0; k < 40; k++) begin
            w0 = ($urandom_range(0, 2) == 0) ? 32'($urandom) : EID;
            w1 = ($urandom_range(0, 2) == 0) ? 32'($urandom) : ETS;
            run_check(rand_stall(), rand_stall(), w0, w1, int'($urandom_range(0, 5) < 4 ? 0 : $urandom_range(1, 2)));
        end

        // Reset while the timestamp read is stalled.
        cfg(0, 100, EID, ETS);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (avm_if.avm_read && avm_if.avm_address) break;
            @(negedge clock);
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_flags", 32'({busy, done, id_match, ts_match, timeout, avm_if.avm_read, avm_if.avm_address}), 32'd0);
        chk("midreset_id_value", id_value, 32'd0);
        sb_q.delete();
        m_idv = '0;
        m_tsv = '0;
        cfg(0, 0, EID, ETS);
        push_exp(0, 0, EID, ETS);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_done(0, n);
        chk("rerun_edges", 32'(n), 32'd4);

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
